fetch_buffer: RTL

Instruction prefetch queue between the PC register/instruction memory (F stage) and the decode stage. Each cycle the PC advances, the `{F_PC, F_Instr}` pair is captured into a DEPTH-entry FIFO. Decode drains the FIFO with a valid/ready handshake. The block drives the PC register's enable, so a full queue freezes fetch. A redirect flush discards all wrong-path entries.

---
 rtl/fetch_buffer.sv | 57 +++++
 1 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch FIFO between fetch and decode with valid/ready drain and redirect flush.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              F_PC,
  input  logic [31:0]              F_Instr,
  input  logic                     F_Flush,
  output logic                     F_PC_EN,
  output logic                     D_Valid,
  input  logic                     D_Ready,
  output logic [31:0]              D_PC,
  output logic [31:0]              D_Instr,
  output logic                     F_Full,
  output logic [$clog2(DEPTH):0]   F_Count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RESET_PC[1:0] != 2'b00) begin : g_bad_param
    $error("fetch_buffer: DEPTH must be a power of two >= 2 and RESET_PC word aligned");
  end
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  assign F_Full  = count == FULL;
  assign F_Count = count;
  assign D_Valid = count != '0;
  assign D_PC    = mem[rd_ptr][63:32];
  assign D_Instr = mem[rd_ptr][31:0];
  assign pop     = D_Valid & D_Ready;
  // A full queue may still take a fetch when decode drains the head in the same cycle.
  assign F_PC_EN = reset & (F_Flush | ~F_Full | D_Ready);
  assign push    = F_PC_EN & ~F_Flush;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {F_PC, F_Instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (F_Flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        count  <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      end
    end
  end
endmodule
